// File: rtl/sntc_ldpc_run_pkg.sv
// sntc_ldpc_run_pkg
// Shared types and constants for the LDPC run controller:
//   run_state_t  : controller FSM states
//   ST_*         : result status codes reported on out_status
//   PROB_CEIL    : upper bound for the decoder probability (hundredths of %)
//   prob_bump()  : raise a probability by a step, clamped at PROB_CEIL
package sntc_ldpc_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_START,
    S_RUN,
    S_DONE
  } run_state_t;

  localparam logic [1:0] ST_OK      = 2'b01;
  localparam logic [1:0] ST_GIVEUP  = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  localparam logic [31:0] PROB_CEIL = 32'd10000;

  // The sum is formed one bit wider so a huge step cannot wrap below the ceiling.
  function automatic logic [31:0] prob_bump(input logic [31:0] prob,
                                            input logic [31:0] step);
    logic [32:0] sum;
    sum = {1'b0, prob} + {1'b0, step};
    if (sum > {1'b0, PROB_CEIL}) begin
      return PROB_CEIL;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/sntc_ldpc_run_timer.sv
// sntc_ldpc_run_timer
// Saturating per-attempt cycle counter with budget compare.
// Ports:
//   clk, rstn    : clock, asynchronous active-low reset
//   i_clear      : zero the counter (start of an attempt)
//   i_enable     : count this cycle (controller is in RUN)
//   i_cycle_max  : cycle budget, 0 = unlimited
//   o_count      : cycles spent in RUN including the current one
//   o_expired    : budget reached in the current RUN cycle
module sntc_ldpc_run_timer
  import sntc_ldpc_run_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_clear,
  input  logic         i_enable,
  input  logic [W-1:0] i_cycle_max,
  output logic [W-1:0] o_count,
  output logic         o_expired
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_count_inc;

  // The reported count includes the cycle in progress, so a decision taken
  // in the Nth RUN cycle reports N and the budget trips on that same cycle.
  always_comb begin
    w_count_inc = (&r_count) ? r_count : r_count + W'(1);
    o_count     = w_count_inc;
    o_expired   = i_enable && (i_cycle_max != '0) && (w_count_inc >= i_cycle_max);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_count_inc;
    end
  end

endmodule

// File: rtl/sntc_ldpc_run_ctrl.sv
// sntc_ldpc_run_ctrl
// Sequences the LDPC decoder wrapper one frame at a time: accepts a frame,
// pulses clr/start, watches convergence under a cycle budget, retries with a
// raised probability, and returns decoded bits plus status.
// Ports:
//   clk, rstn                      : clock, asynchronous active-low reset
//   in_valid/in_ready, in_q0,
//   in_exp_syn                     : frame input handshake and payload
//   cfg_prob_base/step, cfg_cycle_max : attempt configuration
//   dec_q0, dec_exp_syn, dec_percent_probability_int,
//   dec_clr, dec_start             : drive to decoder wrapper
//   dec_converged(_valid), dec_tmp_bit : decoder feedback
//   out_valid/out_ready, out_bit, out_status, out_attempts, out_cycles : result
//   stat_ok, stat_fail             : frame counters, present only when
//                                    SNTC_LDPC_RUN_STATS_EN is defined
module sntc_ldpc_run_ctrl
  import sntc_ldpc_run_pkg::*;
#(
  parameter int NN        = 'h0d0,
  parameter int MM        = 'h0a8,
  parameter int SUM_LEN   = 32,
  parameter int RETRY_MAX = 3,
  parameter int AW        = $clog2(RETRY_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NN-1:0][1:0]    in_q0,
  input  logic [MM-1:0]         in_exp_syn,
  input  logic [31:0]           cfg_prob_base,
  input  logic [31:0]           cfg_prob_step,
  input  logic [SUM_LEN-1:0]    cfg_cycle_max,
  output logic [NN-1:0][1:0]    dec_q0,
  output logic [MM-1:0]         dec_exp_syn,
  output logic [31:0]           dec_percent_probability_int,
  output logic                  dec_clr,
  output logic                  dec_start,
  input  logic [1:0]            dec_converged,
  input  logic                  dec_converged_valid,
  input  logic [NN-1:0]         dec_tmp_bit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NN-1:0]         out_bit,
  output logic [1:0]            out_status,
  output logic [AW-1:0]         out_attempts,
  output logic [SUM_LEN-1:0]    out_cycles
`ifdef SNTC_LDPC_RUN_STATS_EN
  ,
  output logic [31:0]           stat_ok,
  output logic [31:0]           stat_fail
`endif
);

  run_state_t          r_state;
  run_state_t          w_next;
  logic [NN-1:0][1:0]  r_q0;
  logic [MM-1:0]       r_syn;
  logic [31:0]         r_prob;
  logic [AW-1:0]       r_attempt;
  logic [SUM_LEN-1:0]  r_cycle_max;
  logic [NN-1:0]       r_out_bit;
  logic [1:0]          r_out_status;
  logic [AW-1:0]       r_out_attempts;
  logic [SUM_LEN-1:0]  r_out_cycles;

  logic                w_run;
  logic                w_accept;
  logic                w_success;
  logic                w_giveup;
  logic                w_expired;
  logic                w_fail;
  logic [1:0]          w_fail_code;
  logic                w_last_attempt;
  logic [SUM_LEN-1:0]  w_count;

  sntc_ldpc_run_timer #(
    .W (SUM_LEN)
  ) u_timer (
    .clk         (clk),
    .rstn        (rstn),
    .i_clear     (r_state == S_START),
    .i_enable    (w_run),
    .i_cycle_max (r_cycle_max),
    .o_count     (w_count),
    .o_expired   (w_expired)
  );

  // Success beats a same-cycle timeout; a give-up beats a same-cycle timeout.
  always_comb begin
    w_run          = (r_state == S_RUN);
    w_accept       = (r_state == S_IDLE) && in_valid;
    w_success      = dec_converged_valid && (dec_converged == ST_OK);
    w_giveup       = dec_converged_valid && (dec_converged == ST_GIVEUP);
    w_fail         = w_run && !w_success && (w_giveup || w_expired);
    w_fail_code    = w_giveup ? ST_GIVEUP : ST_TIMEOUT;
    w_last_attempt = (r_attempt >= AW'(RETRY_MAX));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and the handshake/pulse outputs, which are pure state decodes.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    dec_clr   = 1'b0;
    dec_start = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_CLR;
      end
      S_CLR: begin
        dec_clr = 1'b1;
        w_next  = S_START;
      end
      S_START: begin
        dec_start = 1'b1;
        w_next    = S_RUN;
      end
      S_RUN: begin
        if (w_success) begin
          w_next = S_DONE;
        end else if (w_fail) begin
          w_next = w_last_attempt ? S_DONE : S_CLR;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Frame, attempt and result registers. Results are only written on the way
  // into DONE so they hold steady while the consumer stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q0           <= '0;
      r_syn          <= '0;
      r_prob         <= '0;
      r_attempt      <= '0;
      r_cycle_max    <= '0;
      r_out_bit      <= '0;
      r_out_status   <= '0;
      r_out_attempts <= '0;
      r_out_cycles   <= '0;
    end else begin
      if (w_accept) begin
        r_q0        <= in_q0;
        r_syn       <= in_exp_syn;
        r_prob      <= cfg_prob_base;
        r_attempt   <= AW'(1);
        r_cycle_max <= cfg_cycle_max;
      end
      if (w_run) begin
        if (w_success) begin
          r_out_bit      <= dec_tmp_bit;
          r_out_status   <= ST_OK;
          r_out_attempts <= r_attempt;
          r_out_cycles   <= w_count;
        end else if (w_fail) begin
          if (!w_last_attempt) begin
            r_prob      <= prob_bump(r_prob, cfg_prob_step);
            r_attempt   <= r_attempt + AW'(1);
            r_cycle_max <= cfg_cycle_max;
          end else begin
            r_out_bit      <= dec_tmp_bit;
            r_out_status   <= w_fail_code;
            r_out_attempts <= r_attempt;
            r_out_cycles   <= w_count;
          end
        end
      end
    end
  end

  assign dec_q0                      = r_q0;
  assign dec_exp_syn                 = r_syn;
  assign dec_percent_probability_int = r_prob;
  assign out_bit                     = r_out_bit;
  assign out_status                  = r_out_status;
  assign out_attempts                = r_out_attempts;
  assign out_cycles                  = r_out_cycles;

`ifdef SNTC_LDPC_RUN_STATS_EN
  logic [31:0] r_stat_ok;
  logic [31:0] r_stat_fail;

  // Counted on the result handshake; both wrap and only rstn clears them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stat_ok   <= '0;
      r_stat_fail <= '0;
    end else if ((r_state == S_DONE) && out_ready) begin
      if (r_out_status == ST_OK) begin
        r_stat_ok <= r_stat_ok + 32'd1;
      end else begin
        r_stat_fail <= r_stat_fail + 32'd1;
      end
    end
  end

  assign stat_ok   = r_stat_ok;
  assign stat_fail = r_stat_fail;
`endif

endmodule

// File: tb/tb_sntc_ldpc_run_ctrl.sv
// tb_sntc_ldpc_run_ctrl
// Self-checking bench for sntc_ldpc_run_ctrl. A scripted decoder model answers
// each dec_start; expected results are queued at frame launch and compared
// when out_valid appears. Stat ports are exercised when SNTC_LDPC_RUN_STATS_EN
// is defined.
module tb_sntc_ldpc_run_ctrl;

  localparam int NN        = 208;
  localparam int MM        = 168;
  localparam int SUM_LEN   = 32;
  localparam int RETRY_MAX = 3;
  localparam int AW        = 2;

  logic                 clk;
  logic                 rstn;
  logic                 in_valid;
  logic                 in_ready;
  logic [NN-1:0][1:0]   in_q0;
  logic [MM-1:0]        in_exp_syn;
  logic [31:0]          cfg_prob_base;
  logic [31:0]          cfg_prob_step;
  logic [SUM_LEN-1:0]   cfg_cycle_max;
  logic [NN-1:0][1:0]   dec_q0;
  logic [MM-1:0]        dec_exp_syn;
  logic [31:0]          dec_percent_probability_int;
  logic                 dec_clr;
  logic                 dec_start;
  logic [1:0]           dec_converged;
  logic                 dec_converged_valid;
  logic [NN-1:0]        dec_tmp_bit;
  logic                 out_valid;
  logic                 out_ready;
  logic [NN-1:0]        out_bit;
  logic [1:0]           out_status;
  logic [AW-1:0]        out_attempts;
  logic [SUM_LEN-1:0]   out_cycles;
`ifdef SNTC_LDPC_RUN_STATS_EN
  logic [31:0]          stat_ok;
  logic [31:0]          stat_fail;
`endif

  sntc_ldpc_run_ctrl #(
    .NN        (NN),
    .MM        (MM),
    .SUM_LEN   (SUM_LEN),
    .RETRY_MAX (RETRY_MAX),
    .AW        (AW)
  ) dut (
    .clk                         (clk),
    .rstn                        (rstn),
    .in_valid                    (in_valid),
    .in_ready                    (in_ready),
    .in_q0                       (in_q0),
    .in_exp_syn                  (in_exp_syn),
    .cfg_prob_base               (cfg_prob_base),
    .cfg_prob_step               (cfg_prob_step),
    .cfg_cycle_max               (cfg_cycle_max),
    .dec_q0                      (dec_q0),
    .dec_exp_syn                 (dec_exp_syn),
    .dec_percent_probability_int (dec_percent_probability_int),
    .dec_clr                     (dec_clr),
    .dec_start                   (dec_start),
    .dec_converged               (dec_converged),
    .dec_converged_valid         (dec_converged_valid),
    .dec_tmp_bit                 (dec_tmp_bit),
    .out_valid                   (out_valid),
    .out_ready                   (out_ready),
    .out_bit                     (out_bit),
    .out_status                  (out_status),
    .out_attempts                (out_attempts),
    .out_cycles                  (out_cycles)
`ifdef SNTC_LDPC_RUN_STATS_EN
    ,
    .stat_ok                     (stat_ok),
    .stat_fail                   (stat_fail)
`endif
  );

  typedef struct {
    logic [1:0]    status;
    logic [AW-1:0] attempts;
    logic [31:0]   cycles;
    logic [NN-1:0] bits;
  } expRes_t;

  expRes_t            expQ[$];
  int                 testsRun    = 0;
  int                 testsFailed = 0;
  int                 kindArr[3];
  int                 delayArr[3];
  logic [31:0]        expProb[3];
  logic [NN-1:0][1:0] curQ0;
  logic [MM-1:0]      curSyn;
  int                 decAttempt;
  int                 expOk;
  int                 expFail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [511:0] got,
                             input logic [511:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scripted decoder: kind 0 = stay silent, 1 = converge ok, 2 = give up,
  // reported in RUN cycle delayArr[attempt].
  initial begin
    int idx;
    dec_converged_valid = 1'b0;
    dec_converged       = 2'b00;
    forever begin
      @(negedge clk);
      if (dec_start) begin
        idx = decAttempt;
        decAttempt++;
        checkOutput("attemptIdx", 512'(idx < RETRY_MAX), 512'(1));
        if (idx < RETRY_MAX) begin
          checkOutput("decProb", 512'(dec_percent_probability_int), 512'(expProb[idx]));
          checkOutput("decQ0", 512'(dec_q0), 512'(curQ0));
          checkOutput("decSyn", 512'(dec_exp_syn), 512'(curSyn));
          if (kindArr[idx] != 0) begin
            repeat (delayArr[idx]) @(posedge clk);
            #1;
            dec_converged_valid = 1'b1;
            dec_converged       = (kindArr[idx] == 1) ? 2'b01 : 2'b10;
            @(posedge clk);
            #1;
            dec_converged_valid = 1'b0;
            dec_converged       = 2'b00;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input int base, input int step, input int cmax,
                               input int k0, input int d0, input int k1, input int d1,
                               input int k2, input int d2, input bit doPush);
    expRes_t e;
    int      p;
    bit      done;
    logic [NN-1:0] tmp;
    kindArr[0] = k0; delayArr[0] = d0;
    kindArr[1] = k1; delayArr[1] = d1;
    kindArr[2] = k2; delayArr[2] = d2;
    for (int i = 0; i < NN; i++) tmp[i] = 1'($urandom);
    for (int i = 0; i < NN; i++) curQ0[i] = 2'($urandom);
    for (int i = 0; i < MM; i++) curSyn[i] = 1'($urandom);
    p    = base;
    done = 1'b0;
    e.bits = tmp;
    for (int a = 0; a < RETRY_MAX; a++) begin
      if (!done) begin
        expProb[a] = p;
        e.attempts = AW'(a + 1);
        if (kindArr[a] != 0 && (cmax == 0 || delayArr[a] <= cmax)) begin
          e.status = (kindArr[a] == 1) ? 2'b01 : 2'b10;
          e.cycles = delayArr[a];
        end else begin
          e.status = 2'b11;
          e.cycles = cmax;
        end
        if (e.status == 2'b01) begin
          done = 1'b1;
        end else begin
          p = (p + step > 10000) ? 10000 : p + step;
        end
      end
    end
    if (doPush) expQ.push_back(e);
    @(negedge clk);
    decAttempt    = 0;
    dec_tmp_bit   = tmp;
    in_q0         = curQ0;
    in_exp_syn    = curSyn;
    cfg_prob_base = base;
    cfg_prob_step = step;
    cfg_cycle_max = cmax;
    in_valid      = 1'b1;
    checkOutput("inReadyIdle", 512'(in_ready), 512'(1));
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_q0      = ~curQ0;
    in_exp_syn = ~curSyn;
    @(negedge clk);
    checkOutput("clrPulse", 512'(dec_clr), 512'(1));
    @(negedge clk);
    checkOutput("startPulse", 512'(dec_start), 512'(1));
  endtask

  task automatic collectResult(input int hold);
    expRes_t e;
    int      waitCnt;
    waitCnt = 0;
    @(negedge clk);
    while (!out_valid && waitCnt < 300) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("outValid", 512'(out_valid), 512'(1));
    if (expQ.size() == 0) begin
      checkOutput("queueEmpty", 512'(0), 512'(1));
      return;
    end
    e = expQ.pop_front();
    checkOutput("outStatus", 512'(out_status), 512'(e.status));
    checkOutput("outAttempts", 512'(out_attempts), 512'(e.attempts));
    checkOutput("outCycles", 512'(out_cycles), 512'(e.cycles));
    checkOutput("outBit", 512'(out_bit), 512'(e.bits));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("holdValid", 512'(out_valid), 512'(1));
      checkOutput("holdStatus", 512'(out_status), 512'(e.status));
      checkOutput("holdCycles", 512'(out_cycles), 512'(e.cycles));
      checkOutput("holdBit", 512'(out_bit), 512'(e.bits));
      checkOutput("holdInReady", 512'(in_ready), 512'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    if (e.status == 2'b01) expOk++;
    else expFail++;
    @(negedge clk);
    checkOutput("outValidDrop", 512'(out_valid), 512'(0));
    checkOutput("inReadyBack", 512'(in_ready), 512'(1));
  endtask

  task automatic checkStats();
`ifdef SNTC_LDPC_RUN_STATS_EN
    checkOutput("statOk", 512'(stat_ok), 512'(expOk));
    checkOutput("statFail", 512'(stat_fail), 512'(expFail));
`endif
  endtask

  initial begin
    bit sawValid;
    rstn          = 1'b0;
    in_valid      = 1'b0;
    in_q0         = '0;
    in_exp_syn    = '0;
    cfg_prob_base = '0;
    cfg_prob_step = '0;
    cfg_cycle_max = '0;
    dec_tmp_bit   = '0;
    out_ready     = 1'b0;
    decAttempt    = 0;
    expOk         = 0;
    expFail       = 0;
    for (int a = 0; a < RETRY_MAX; a++) expProb[a] = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstInReady", 512'(in_ready), 512'(1));
    checkOutput("rstOutValid", 512'(out_valid), 512'(0));
    checkOutput("rstClrStart", 512'({dec_clr, dec_start}), 512'(0));
    checkOutput("rstProb", 512'(dec_percent_probability_int), 512'(0));
    checkOutput("rstOutFields", 512'({out_status, out_attempts, out_cycles}), 512'(0));
    checkStats();
    rstn = 1'b1;

    // A stray convergence report while idle must not produce a result.
    @(negedge clk);
    dec_converged_valid = 1'b1;
    dec_converged       = 2'b01;
    @(negedge clk);
    dec_converged_valid = 1'b0;
    dec_converged       = 2'b00;
    @(negedge clk);
    checkOutput("idleConvIgnored", 512'(out_valid), 512'(0));

    applyStimulus(5000, 1000, 0, 1, 5, 0, 0, 0, 0, 1'b1);
    collectResult(0);
    applyStimulus(4500, 2000, 0, 2, 3, 2, 4, 1, 6, 1'b1);
    collectResult(0);
    applyStimulus(3000, 500, 10, 0, 0, 0, 0, 0, 0, 1'b1);
    collectResult(0);
    applyStimulus(9000, 2000, 0, 2, 2, 1, 3, 0, 0, 1'b1);
    collectResult(0);
    applyStimulus(1000, 0, 5, 1, 5, 0, 0, 0, 0, 1'b1);
    collectResult(4);
    applyStimulus(100, 100, 4, 2, 4, 2, 4, 2, 4, 1'b1);
    collectResult(0);
    checkStats();

    // Reset in the middle of RUN: frame dropped, everything back to reset values.
    applyStimulus(2000, 100, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #2;
    checkOutput("midRstInReady", 512'(in_ready), 512'(1));
    checkOutput("midRstOutValid", 512'(out_valid), 512'(0));
    checkOutput("midRstProb", 512'(dec_percent_probability_int), 512'(0));
    checkOutput("midRstQ0", 512'(dec_q0), 512'(0));
    checkOutput("midRstOutFields", 512'({out_status, out_attempts, out_cycles}), 512'(0));
    checkOutput("midRstOutBit", 512'(out_bit), 512'(0));
    expOk   = 0;
    expFail = 0;
    checkStats();
    @(negedge clk);
    rstn = 1'b1;
    sawValid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("noResultAfterRst", 512'(sawValid), 512'(0));

    applyStimulus(6000, 1000, 0, 1, 2, 0, 0, 0, 0, 1'b1);
    collectResult(0);
    applyStimulus(6000, 1000, 0, 1, 7, 0, 0, 0, 0, 1'b1);
    collectResult(0);
    applyStimulus(6000, 1000, 3, 0, 0, 2, 1, 0, 0, 1'b1);
    collectResult(0);
    checkStats();

    checkOutput("queueDrained", 512'(expQ.size()), 512'(0));
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
